tmds_encoder_pipe: RTL and testbench
====================================

# tmds_encoder_pipe

Parametrised, pipelined DVI/TMDS 8b/10b encoder for NUM_CH independent lanes, with per-lane running disparity, control-period symbols and clock-enable stall. Sits in the pixel-clock domain between the video timing generator (counters, sync, draw-area) and the per-lane 10:1 serializers. Supersedes the single-lane combinational encoder: the decision and disparity state are registered inside the block, so the caller no longer feeds the previous count back in.

## Interface
- NUM_CH, 3, number of TMDS lanes (1..4); lane 0 = blue, 1 = green, 2 = red
- CNT_W, 5, signed running-disparity width per lane (min 5)
- pix_clk  in  1  pixel clock; all state on rising edge
- rst  in  1  reset; synchronous, active-high; priority over everything
- ce  in  1  clock enable; when 0 all registers hold
- de  in  1  data enable (draw area), shared by all lanes
- data  in  8*NUM_CH  pixel bytes, lane i = data[8i+7:8i]
- ctrl  in  2*NUM_CH  control pairs, lane i = {C1,C0} = ctrl[2i+1:2i]
- gb  in  1  guard-band request (used only with TMDS_GUARD_BAND_EN)
- tmds  out  10*NUM_CH  encoded symbols, lane i = tmds[10i+9:10i], bit 0 transmitted first
- valid  out  1  high once pipeline holds real symbols
- cnt_dbg  out  CNT_W*NUM_CH  registered running disparity per lane

## Operation
- Stage 1 (per lane, registered): n1d = ones(D). Use XNOR iff n1d>4 or (n1d==4 and D[0]==0). q_m[0]=D[0]; q_m[k]=q_m[k-1] XOR/XNOR D[k], k=1..7; q_m[8]=0 for XNOR, 1 for XOR. de, ctrl and gb registered alongside.
- Stage 2 (per lane, registered), n1q=ones(q_m[7:0]), n0q=8-n1q, cnt=lane disparity:
  - de=1, cnt==0 or n1q==4: tmds={~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m8 ? n1q-n0q : n0q-n1q.
  - de=1, (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q): tmds={1, q_m8, ~q_m[7:0]}; cnt += 2*q_m8 + n0q-n1q.
  - de=1, otherwise: tmds={0, q_m8, q_m[7:0]}; cnt += -2*(~q_m8) + n1q-n0q.
  - de=0: cnt=0; tmds by {C1,C0}: 00→10'b1101010100, 01→10'b0010101011, 10→10'b0101010100, 11→10'b1010101011.
- Arithmetic in CNT_W-bit signed; legal range ±10 never overflows at CNT_W≥5; no saturation logic.
- Lanes fully independent; each keeps its own cnt.

## Timing
- Latency: 2 ce-qualified cycles, input to tmds/valid/cnt_dbg.
- Reset values: tmds every lane = 10'b1101010100; cnt_dbg = 0; valid = 0; stage-1 regs cleared (de=0, ctrl=0, gb=0).
- valid rises on the 2nd ce cycle after rst deasserts; stays high until rst.
- ce=0: no register changes, outputs frozen; resuming continues exactly where stalled.
- rst mid-frame: next edge forces reset values regardless of ce; disparity history lost.
- de 1→0: first control symbol appears 2 cycles later; cnt is 0 on that same edge.
- de 0→1: first data symbol uses cnt=0 (first branch).

## Configuration
- TMDS_GUARD_BAND_EN defined: stage 2, when registered gb=1 and de=0, overrides control code with video guard band: lanes 0 and 2 = 10'b1011001100, lane 1 = 10'b0100110011, lane 3 = 10'b1011001100; cnt forced 0. gb with de=1 ignored (data wins).
- Undefined: gb port present but ignored; no guard-band logic synthesised.

## Test plan
- Reset: hold rst 3 cycles with ce=1, random inputs → all tmds=0x354, cnt_dbg=0, valid=0; valid=1 two cycles after release.
- Control symbols: de=0, lane 0 ctrl 00/01/10/11 → 0x354, 0x0AB, 0x154, 0x2AB after 2 cycles; cnt_dbg=0.
- Zero run: de=1, D=0x00 × 3 from cnt 0 → tmds 0x100, 0x3FF, 0x100; cnt −8, +2, −6.
- All-ones: de=1, D=0xFF × 2 from cnt 0 → tmds 0x200, 0x0FF; cnt −8, −2; then de=0 → cnt 0.
- Stall: mid zero-run drop ce 5 cycles → tmds and cnt_dbg frozen; on ce=1 sequence continues unchanged; rst during stall → reset values next edge.
- Guard band (macro defined): de=0, gb=1 → lane0 0x2CC, lane1 0x133, lane2 0x2CC; macro undefined → control codes.

Source files
------------

// File: rtl/tmds_encoder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tmds_encoder_pipe : 2-stage DVI/TMDS 8b/10b encoder, NUM_CH lanes,       |
// | per-lane running disparity. Macro TMDS_GUARD_BAND_EN adds guard bands.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tmds_encoder_pipe #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                      pix_clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      de,
  input  logic [8*NUM_CH-1:0]       data,
  input  logic [2*NUM_CH-1:0]       ctrl,
  input  logic                      gb,
  output logic [10*NUM_CH-1:0]      tmds,
  output logic                      valid,
  output logic [CNT_W*NUM_CH-1:0]   cnt_dbg
);

  localparam logic [9:0]       c_ctrl00 = 10'b1101010100;
  localparam logic [9:0]       c_ctrl01 = 10'b0010101011;
  localparam logic [9:0]       c_ctrl10 = 10'b0101010100;
  localparam logic [9:0]       c_ctrl11 = 10'b1010101011;
  localparam logic [CNT_W-1:0] c_zero   = '0;
  localparam logic [CNT_W-1:0] c_two    = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_eight  = CNT_W'(8);

  function automatic logic [3:0] f_ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, v[k]};
    return n;
  endfunction

  // Transition-minimising stage: XOR or XNOR chain, bit 8 records which.
  function automatic logic [8:0] f_qm(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       x;
    n1   = f_ones(d);
    x    = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int k = 1; k < 8; k++) q[k] = x ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    q[8] = ~x;
    return q;
  endfunction

  logic r_de1;
  logic r_vld1;
  logic r_valid;

`ifdef TMDS_GUARD_BAND_EN
  logic r_gb1;
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_gb1 <= 1'b0;
    end else if (ce) begin
      r_gb1 <= gb;
    end
  end
`else
  logic w_unused_gb;
  assign w_unused_gb = gb;
`endif

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_de1   <= 1'b0;
      r_vld1  <= 1'b0;
      r_valid <= 1'b0;
    end else if (ce) begin
      r_de1   <= de;
      r_vld1  <= 1'b1;
      r_valid <= r_vld1;
    end
  end

  assign valid = r_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic [8:0]       r_qm;
    logic [1:0]       r_ctrl;
    logic [9:0]       r_tmds;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_n1q;
    logic [CNT_W-1:0] w_bal;
    logic             w_pos;
    logic             w_neg;
    logic [9:0]       w_tmds_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

`ifdef TMDS_GUARD_BAND_EN
    localparam logic [9:0] c_gb_lane = (i == 1) ? 10'b0100110011 : 10'b1011001100;
`endif

    // w_bal is n1q - n0q, carried in the disparity width.
    assign w_n1q = f_ones(r_qm[7:0]);
    assign w_bal = CNT_W'({w_n1q, 1'b0}) - c_eight;
    assign w_pos = !r_cnt[CNT_W-1] && (r_cnt != c_zero);
    assign w_neg = r_cnt[CNT_W-1];

    always_comb begin
      w_tmds_nxt = c_ctrl00;
      w_cnt_nxt  = c_zero;
      if (r_de1) begin
        if ((r_cnt == c_zero) || (w_n1q == 4'd4)) begin
          w_tmds_nxt = {~r_qm[8], r_qm[8], (r_qm[8] ? r_qm[7:0] : ~r_qm[7:0])};
          w_cnt_nxt  = r_cnt + (r_qm[8] ? w_bal : (c_zero - w_bal));
        end else if ((w_pos && (w_n1q > 4'd4)) || (w_neg && (w_n1q < 4'd4))) begin
          w_tmds_nxt = {1'b1, r_qm[8], ~r_qm[7:0]};
          w_cnt_nxt  = r_cnt + (r_qm[8] ? c_two : c_zero) - w_bal;
        end else begin
          w_tmds_nxt = {1'b0, r_qm[8], r_qm[7:0]};
          w_cnt_nxt  = r_cnt + w_bal - (r_qm[8] ? c_zero : c_two);
        end
      end else begin
        case (r_ctrl)
          2'b00:   w_tmds_nxt = c_ctrl00;
          2'b01:   w_tmds_nxt = c_ctrl01;
          2'b10:   w_tmds_nxt = c_ctrl10;
          default: w_tmds_nxt = c_ctrl11;
        endcase
`ifdef TMDS_GUARD_BAND_EN
        if (r_gb1) w_tmds_nxt = c_gb_lane;
`endif
      end
    end

    always_ff @(posedge pix_clk) begin
      if (rst) begin
        r_qm   <= '0;
        r_ctrl <= '0;
        r_tmds <= c_ctrl00;
        r_cnt  <= c_zero;
      end else if (ce) begin
        r_qm   <= f_qm(data[8*i +: 8]);
        r_ctrl <= ctrl[2*i +: 2];
        r_tmds <= w_tmds_nxt;
        r_cnt  <= w_cnt_nxt;
      end
    end

    assign tmds[10*i +: 10]       = r_tmds;
    assign cnt_dbg[CNT_W*i +: CNT_W] = r_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder_pipe.sv
`default_nettype none
// Directed bench for tmds_encoder_pipe (3 lanes, 5-bit disparity).
module tb_tmds_encoder_pipe;

  logic        pix_clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        de = 1'b0;
  logic [23:0] data = '0;
  logic [5:0]  ctrl = '0;
  logic        gb = 1'b0;
  logic [29:0] tmds;
  logic        valid;
  logic [14:0] cnt_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  tmds_encoder_pipe #(.NUM_CH(3), .CNT_W(5)) dut (
    .pix_clk (pix_clk),
    .rst     (rst),
    .ce      (ce),
    .de      (de),
    .data    (data),
    .ctrl    (ctrl),
    .gb      (gb),
    .tmds    (tmds),
    .valid   (valid),
    .cnt_dbg (cnt_dbg)
  );

  always #5 pix_clk = ~pix_clk;

  task automatic step();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ce  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data = 24'($urandom);
      ctrl = 6'($urandom);
      de   = 1'($urandom);
      gb   = 1'($urandom);
      step();
      n_tests++;
      if (tmds !== {3{10'h354}}) begin
        n_fail++;
        $display("FAIL reset_tmds: got %h expected %h", tmds, {3{10'h354}});
      end
      n_tests++;
      if (cnt_dbg !== 15'h0 || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_cnt_valid: got cnt=%h valid=%b expected cnt=0 valid=0", cnt_dbg, valid);
      end
    end
    rst = 1'b0; de = 1'b0; ctrl = '0; data = '0; gb = 1'b0;
    step();
    n_tests++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_early: got %b expected 0", valid);
    end
    step();
    n_tests++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_rise: got %b expected 1", valid);
    end
  endtask

  task automatic test_control();
    logic [9:0] exp_code [4];
    exp_code[0] = 10'h354; exp_code[1] = 10'h0AB;
    exp_code[2] = 10'h154; exp_code[3] = 10'h2AB;
    de = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ctrl = {4'b0000, 2'(c)};
      step(); step();
      n_tests++;
      if (tmds !== {10'h354, 10'h354, exp_code[c]}) begin
        n_fail++;
        $display("FAIL ctrl_%0d: got %h expected %h", c, tmds, {10'h354, 10'h354, exp_code[c]});
      end
      n_tests++;
      if (cnt_dbg !== 15'h0) begin
        n_fail++;
        $display("FAIL ctrl_cnt_%0d: got %h expected 0", c, cnt_dbg);
      end
    end
    ctrl = '0;
  endtask

  task automatic test_zero_run();
    logic [9:0] exp_t [3];
    logic [4:0] exp_c [3];
    exp_t[0] = 10'h100; exp_t[1] = 10'h3FF; exp_t[2] = 10'h100;
    exp_c[0] = 5'h18;   exp_c[1] = 5'h02;   exp_c[2] = 5'h1A;
    de = 1'b1; data = 24'h000000;
    step();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) de = 1'b0;
      step();
      n_tests++;
      if (tmds !== {3{exp_t[k]}} || cnt_dbg !== {3{exp_c[k]}}) begin
        n_fail++;
        $display("FAIL zero_run_%0d: got tmds=%h cnt=%h expected tmds=%h cnt=%h",
                 k, tmds, cnt_dbg, {3{exp_t[k]}}, {3{exp_c[k]}});
      end
    end
    step();
    n_tests++;
    if (tmds !== {3{10'h354}} || cnt_dbg !== 15'h0) begin
      n_fail++;
      $display("FAIL zero_run_end: got tmds=%h cnt=%h expected tmds=%h cnt=0", tmds, cnt_dbg, {3{10'h354}});
    end
  endtask

  task automatic test_all_ones();
    de = 1'b1; data = 24'hFFFFFF;
    step(); step();
    n_tests++;
    if (tmds !== {3{10'h200}} || cnt_dbg !== {3{5'h18}}) begin
      n_fail++;
      $display("FAIL ones_0: got tmds=%h cnt=%h expected tmds=%h cnt=%h", tmds, cnt_dbg, {3{10'h200}}, {3{5'h18}});
    end
    de = 1'b0;
    step();
    n_tests++;
    if (tmds !== {3{10'h0FF}} || cnt_dbg !== {3{5'h1E}}) begin
      n_fail++;
      $display("FAIL ones_1: got tmds=%h cnt=%h expected tmds=%h cnt=%h", tmds, cnt_dbg, {3{10'h0FF}}, {3{5'h1E}});
    end
    step();
    n_tests++;
    if (tmds !== {3{10'h354}} || cnt_dbg !== 15'h0) begin
      n_fail++;
      $display("FAIL ones_ctrl: got tmds=%h cnt=%h expected tmds=%h cnt=0", tmds, cnt_dbg, {3{10'h354}});
    end
  endtask

  task automatic test_lanes();
    // lane2 0x55 stays balanced, lane1 0xFF, lane0 0x00: independent disparity
    de = 1'b1; data = 24'h55FF00;
    step(); step();
    n_tests++;
    if (tmds !== {10'h133, 10'h200, 10'h100} || cnt_dbg !== {5'h00, 5'h18, 5'h18}) begin
      n_fail++;
      $display("FAIL lanes_0: got tmds=%h cnt=%h expected tmds=%h cnt=%h",
               tmds, cnt_dbg, {10'h133, 10'h200, 10'h100}, {5'h00, 5'h18, 5'h18});
    end
    de = 1'b0;
    step();
    n_tests++;
    if (tmds !== {10'h133, 10'h0FF, 10'h3FF} || cnt_dbg !== {5'h00, 5'h1E, 5'h02}) begin
      n_fail++;
      $display("FAIL lanes_1: got tmds=%h cnt=%h expected tmds=%h cnt=%h",
               tmds, cnt_dbg, {10'h133, 10'h0FF, 10'h3FF}, {5'h00, 5'h1E, 5'h02});
    end
    step();
  endtask

  task automatic test_stall();
    de = 1'b1; data = 24'h000000;
    step(); step();
    n_tests++;
    if (tmds !== {3{10'h100}} || cnt_dbg !== {3{5'h18}}) begin
      n_fail++;
      $display("FAIL stall_pre: got tmds=%h cnt=%h expected tmds=%h cnt=%h", tmds, cnt_dbg, {3{10'h100}}, {3{5'h18}});
    end
    ce = 1'b0; de = 1'b0; data = 24'hFFFFFF; ctrl = 6'h3F;
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if (tmds !== {3{10'h100}} || cnt_dbg !== {3{5'h18}} || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got tmds=%h cnt=%h valid=%b expected tmds=%h cnt=%h valid=1",
                 k, tmds, cnt_dbg, valid, {3{10'h100}}, {3{5'h18}});
      end
    end
    ce = 1'b1; de = 1'b1; data = 24'h000000; ctrl = '0;
    step();
    n_tests++;
    if (tmds !== {3{10'h3FF}} || cnt_dbg !== {3{5'h02}}) begin
      n_fail++;
      $display("FAIL stall_resume_0: got tmds=%h cnt=%h expected tmds=%h cnt=%h", tmds, cnt_dbg, {3{10'h3FF}}, {3{5'h02}});
    end
    step();
    n_tests++;
    if (tmds !== {3{10'h100}} || cnt_dbg !== {3{5'h1A}}) begin
      n_fail++;
      $display("FAIL stall_resume_1: got tmds=%h cnt=%h expected tmds=%h cnt=%h", tmds, cnt_dbg, {3{10'h100}}, {3{5'h1A}});
    end
    ce = 1'b0;
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (tmds !== {3{10'h354}} || cnt_dbg !== 15'h0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_rst: got tmds=%h cnt=%h valid=%b expected tmds=%h cnt=0 valid=0",
               tmds, cnt_dbg, valid, {3{10'h354}});
    end
    rst = 1'b0; ce = 1'b1; de = 1'b0;
    step(); step();
    n_tests++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_rst_valid: got %b expected 1", valid);
    end
  endtask

  task automatic test_guard_band();
    logic [29:0] exp_gb;
`ifdef TMDS_GUARD_BAND_EN
    exp_gb = {10'h2CC, 10'h133, 10'h2CC};
`else
    exp_gb = {3{10'h354}};
`endif
    de = 1'b0; ctrl = '0; gb = 1'b1;
    step(); step();
    n_tests++;
    if (tmds !== exp_gb || cnt_dbg !== 15'h0) begin
      n_fail++;
      $display("FAIL guard_band: got tmds=%h cnt=%h expected tmds=%h cnt=0", tmds, cnt_dbg, exp_gb);
    end
    de = 1'b1; data = 24'h555555;
    step(); step();
    n_tests++;
    if (tmds !== {3{10'h133}} || cnt_dbg !== 15'h0) begin
      n_fail++;
      $display("FAIL guard_band_data: got tmds=%h cnt=%h expected tmds=%h cnt=0", tmds, cnt_dbg, {3{10'h133}});
    end
    de = 1'b0; gb = 1'b0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_control();
    test_zero_run();
    test_all_ones();
    test_lanes();
    test_stall();
    test_guard_band();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
